// File: rtl/adder_op_issue.sv
// rtl/adder_op_issue.sv - request FIFO, credit-gated issue to a fixed-latency adder, tagged response FIFO
// Optional statistics counters: define ADDER_ISSUE_STATS_EN.
module adder_op_issue #(
    parameter int DATA_W    = 8,
    parameter int OP_W      = 2,
    parameter int RES_W     = 9,
    parameter int TAG_W     = 4,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ADD_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic [OP_W-1:0]   add_op,
    input  logic [RES_W-1:0]  add_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_c,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
`ifdef ADDER_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_stall
`endif
);
    localparam int RQ_AW = $clog2(REQ_DEPTH);
    localparam int RS_AW = $clog2(RSP_DEPTH);
    localparam int REQ_W = 2*DATA_W + OP_W + TAG_W;
    localparam int RSP_W = RES_W + TAG_W;
    localparam int CNT_W = $clog2(RSP_DEPTH + ADD_LAT + 1) + 1;

    logic [REQ_W-1:0] req_mem [REQ_DEPTH];
    logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
    logic [RQ_AW:0]   req_wp, req_rp, req_cnt, req_cnt_nxt;
    logic [RS_AW:0]   rsp_wp, rsp_rp, rsp_cnt;
    logic [ADD_LAT-1:0] pipe_v;
    logic [TAG_W-1:0]   pipe_tag [ADD_LAT];
    logic [CNT_W-1:0]   inflight;

    logic req_empty, rsp_empty, rsp_full;
    logic push_req, issue, credit_ok, capture, pop_rsp;
    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;
    logic [TAG_W-1:0]  head_tag;
    logic [RES_W-1:0]  rsp_head_c;
    logic [TAG_W-1:0]  rsp_head_tag;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ADD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_v[i]);
        end
    end

    assign req_cnt   = req_wp - req_rp;
    assign rsp_cnt   = rsp_wp - rsp_rp;
    assign req_empty = (req_cnt == '0);
    assign rsp_empty = (rsp_cnt == '0);
    assign rsp_full  = (rsp_cnt == (RS_AW+1)'(RSP_DEPTH));

    // Credit counts results already launched, so a response slot is reserved at issue time.
    assign credit_ok = (CNT_W'(rsp_cnt) + inflight) < CNT_W'(RSP_DEPTH);
    assign push_req  = req_valid && req_ready;
    assign issue     = !req_empty && credit_ok;
    assign capture   = pipe_v[ADD_LAT-1];
    assign pop_rsp   = rsp_valid && rsp_ready;
    assign req_cnt_nxt = req_cnt + (RQ_AW+1)'(push_req) - (RQ_AW+1)'(issue);

    assign {head_a, head_b, head_op, head_tag} = req_mem[req_rp[RQ_AW-1:0]];
    assign {rsp_head_c, rsp_head_tag}          = rsp_mem[rsp_rp[RS_AW-1:0]];

    assign rsp_valid = !rsp_empty;
    assign rsp_c     = rsp_empty ? '0 : rsp_head_c;
    assign rsp_tag   = rsp_empty ? '0 : rsp_head_tag;
    assign busy      = !req_empty || (|pipe_v) || !rsp_empty;

    always_ff @(posedge clk) begin
        if (push_req) begin
            req_mem[req_wp[RQ_AW-1:0]] <= {req_a, req_b, req_op, req_tag};
        end
        if (capture) begin
            rsp_mem[rsp_wp[RS_AW-1:0]] <= {add_c, pipe_tag[ADD_LAT-1]};
        end
        pipe_tag[0] <= head_tag;
        for (int i = 1; i < ADD_LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_wp    <= '0;
            req_rp    <= '0;
            rsp_wp    <= '0;
            rsp_rp    <= '0;
            pipe_v    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_op    <= '0;
            req_ready <= 1'b0;
        end else begin
            assert (!(capture && rsp_full));
            if (push_req) req_wp <= req_wp + 1'b1;
            if (issue) begin
                req_rp <= req_rp + 1'b1;
                add_a  <= head_a;
                add_b  <= head_b;
                add_op <= head_op;
            end
            if (capture) rsp_wp <= rsp_wp + 1'b1;
            if (pop_rsp) rsp_rp <= rsp_rp + 1'b1;
            pipe_v[0] <= issue;
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            req_ready <= (req_cnt_nxt != (RQ_AW+1)'(REQ_DEPTH));
        end
    end

`ifdef ADDER_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
            if (!req_empty && !credit_ok && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_adder_op_issue.sv
// tb/tb_adder_op_issue.sv - directed self-checking bench for adder_op_issue with a one-register adder model
module tb_adder_op_issue;
    logic       clk;
    logic       reset;
    logic       req_valid, req_ready;
    logic [7:0] req_a, req_b;
    logic [1:0] req_op;
    logic [3:0] req_tag;
    logic [7:0] add_a, add_b;
    logic [1:0] add_op;
    logic [8:0] add_c;
    logic       rsp_valid, rsp_ready;
    logic [8:0] rsp_c;
    logic [3:0] rsp_tag;
    logic       busy;
`ifdef ADDER_ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_stall;
`endif

    adder_op_issue dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_c(add_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_tag(rsp_tag), .busy(busy)
`ifdef ADDER_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Adder with one output register: two edges from launch to DUT sample.
    always_ff @(posedge clk) add_c <= model(add_a, add_b, add_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int send_i, n_tot, tag_base, n_rx, first_rx, last_rx;
    logic [12:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_req();
        req_valid = (send_i < n_tot);
        req_a     = 8'(send_i * 37 + 11);
        req_b     = 8'(send_i * 91 + 200);
        req_op    = 2'(send_i);
        req_tag   = 4'(send_i + tag_base);
    endtask

    task automatic start_stream(input int n, input int tb_tag);
        n_tot = n; tag_base = tb_tag; send_i = 0; n_rx = 0;
        exp_q.delete();
        drive_req();
    endtask

    // One clock of stream traffic: score the response head, log accepts, advance.
    task automatic cycle();
        logic acc;
        logic [12:0] hd;
        acc = req_valid && req_ready;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", rsp_valid, 1'b0);
            end else begin
                hd = exp_q[0];
                check("rsp_c", rsp_c, hd[12:4]);
                check("rsp_tag", rsp_tag, hd[3:0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    n_rx++;
                    last_rx = cyc;
                    if (n_rx == 1) first_rx = cyc;
                end
            end
        end
        if (acc) exp_q.push_back({model(req_a, req_b, req_op), req_tag});
        tick();
        if (acc) send_i++;
        drive_req();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b1;
        n_tot = 0; send_i = 0; tag_base = 0; n_rx = 0; first_rx = 0; last_rx = 0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_add_a", add_a, 8'h00);
        check("rst_add_b", add_b, 8'h00);
        check("rst_add_op", add_op, 2'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_c", rsp_c, 9'h000);
        check("rst_rsp_tag", rsp_tag, 4'h0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        check("rel_req_ready", req_ready, 1'b1);

        // Single request latency
        req_valid = 1'b1; req_a = 8'h05; req_b = 8'h03; req_op = 2'd0; req_tag = 4'h7;
        tick();
        req_valid = 1'b0;
        check("s_busy_queued", busy, 1'b1);
        check("s_add_a_pre", add_a, 8'h00);
        tick();
        check("s_add_a", add_a, 8'h05);
        check("s_add_b", add_b, 8'h03);
        check("s_add_op", add_op, 2'd0);
        tick();
        check("s_rsp_valid_early", rsp_valid, 1'b0);
        tick();
        check("s_rsp_valid", rsp_valid, 1'b1);
        check("s_rsp_c", rsp_c, 9'h008);
        check("s_rsp_tag", rsp_tag, 4'h7);
        check("s_busy_pending", busy, 1'b1);
        tick();
        check("s_rsp_valid_popped", rsp_valid, 1'b0);
        check("s_busy_idle", busy, 1'b0);

        // Back-to-back 8 requests, full throughput
        rsp_ready = 1'b1;
        start_stream(8, 0);
        for (int k = 0; k < 60 && n_rx < 8; k++) begin
            if (send_i < 8) check("b2b_req_ready", req_ready, 1'b1);
            cycle();
        end
        check("b2b_rx_count", n_rx, 8);
        check("b2b_consecutive", last_rx - first_rx, 7);

        // Backpressure: only RSP_DEPTH issued, request FIFO fills
        rsp_ready = 1'b0;
        start_stream(10, 0);
        for (int k = 0; k < 15; k++) cycle();
        check("bp_accepted", send_i, 8);
        check("bp_req_ready", req_ready, 1'b0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        check("bp_rsp_tag_head", rsp_tag, 4'h0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 80 && n_rx < 10; k++) cycle();
        check("bp_rx_count", n_rx, 10);
        check("bp_exp_left", exp_q.size(), 0);
        check("bp_busy_idle", busy, 1'b0);

        // Toggling consumer
        start_stream(16, 3);
        for (int k = 0; k < 200 && n_rx < 16; k++) begin
            rsp_ready = cyc[0];
            cycle();
        end
        check("tog_rx_count", n_rx, 16);
        check("tog_exp_left", exp_q.size(), 0);

        // Reset with work queued, in flight and pending
        rsp_ready = 1'b0;
        start_stream(4, 8);
        for (int k = 0; k < 4; k++) cycle();
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        req_valid = 1'b0;
        n_tot = 0;
        tick();
        check("mid_req_ready", req_ready, 1'b0);
        check("mid_add_a", add_a, 8'h00);
        check("mid_add_b", add_b, 8'h00);
        check("mid_add_op", add_op, 2'd0);
        check("mid_rsp_valid", rsp_valid, 1'b0);
        check("mid_rsp_c", rsp_c, 9'h000);
        check("mid_rsp_tag", rsp_tag, 4'h0);
        check("mid_busy_rst", busy, 1'b0);
        reset = 1'b1;
        rsp_ready = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rel_ready", req_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            check("mid_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        req_valid = 1'b1; req_a = 8'hF0; req_b = 8'h20; req_op = 2'd0; req_tag = 4'hA;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !rsp_valid; k++) tick();
        check("post_rsp_valid", rsp_valid, 1'b1);
        check("post_rsp_c", rsp_c, 9'h110);
        check("post_rsp_tag", rsp_tag, 4'hA);
        tick();
        check("post_idle", busy, 1'b0);

`ifdef ADDER_ISSUE_STATS_EN
        do_reset();
        check("st_rst_issued", stat_issued, 16'd0);
        check("st_rst_stall", stat_stall, 16'd0);
        rsp_ready = 1'b0;
        start_stream(6, 0);
        for (int k = 0; k < 10; k++) cycle();
        check("st_issued_blocked", stat_issued, 16'd4);
        check("st_stall_blocked", stat_stall, 16'd5);
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && n_rx < 6; k++) cycle();
        check("st_rx_count", n_rx, 6);
        check("st_issued_final", stat_issued, 16'd6);
        check("st_stall_final", stat_stall, 16'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
